// File: rtl/mul_iter_pkg.sv
// Shared types and constants for the iterative Booth radix-4 multiplier.
package mul_iter_pkg;

  localparam int MUL_STATE_W = 2;
  localparam int MUL_OPD_W   = 32;

  typedef enum logic [MUL_STATE_W-1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_iter_if.sv
// EX <-> multiplier handshake: EX is the master, mul_iter the slave.
interface mul_iter_if
  import mul_iter_pkg::*;
#(
  parameter int OPD_W = MUL_OPD_W
);
  logic               mult_start_i;
  logic               mult_signed_i;
  logic [OPD_W-1:0]   mult_opd1_i;
  logic [OPD_W-1:0]   mult_opd2_i;
  logic               flush_i;
  logic [2*OPD_W-1:0] product_o;
  logic               mult_end_o;
  logic               mult_busy_o;

  modport master (
    output mult_start_i, mult_signed_i, mult_opd1_i, mult_opd2_i, flush_i,
    input  product_o, mult_end_o, mult_busy_o
  );

  modport slave (
    input  mult_start_i, mult_signed_i, mult_opd1_i, mult_opd2_i, flush_i,
    output product_o, mult_end_o, mult_busy_o
  );
endinterface

// File: rtl/mul_iter_booth_r4_sel.sv
// Radix-4 Booth recode: selects 0/M/2M for one 3-bit group and flags negation.
module booth_r4_sel #(
  parameter int W = 34
) (
  input  logic [2:0] grp,
  input  logic [W-1:0] mcand,
  output logic [W:0]   pp,
  output logic         neg
);

  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (grp)
      3'b001, 3'b010: pp = {mcand[W-1], mcand};
      3'b011:         pp = {mcand, 1'b0};
      3'b100: begin
        pp  = {mcand, 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp  = {mcand[W-1], mcand};
        neg = 1'b1;
      end
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative radix-4 Booth multiplier, one partial product per cycle.
// Optional MUL_ITER_EARLY_EXIT_EN: zero operand skips straight to DONE.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int OPD_W = MUL_OPD_W
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  mul_iter_if.slave mif
);

  localparam int ITERS = OPD_W/2 + 1;
  localparam int XW    = OPD_W + 2;
  localparam int AW    = 2*OPD_W + 4;
  localparam int CW    = $clog2(ITERS);

  mul_state_e         state, state_nxt;
  logic [XW-1:0]      mcand, mplr;
  logic               prev;
  logic [AW-1:0]      acc, acc_nxt, addend, pp_ext;
  logic [CW-1:0]      cnt;
  logic [2*OPD_W-1:0] product;
  logic               end_q;
  logic               accept;
  logic [XW:0]        pp_mag;
  logic               pp_neg;
  logic [XW-1:0]      opd1_ext, opd2_ext;

  assign opd1_ext = mif.mult_signed_i ? {{2{mif.mult_opd1_i[OPD_W-1]}}, mif.mult_opd1_i}
                                      : {2'b00, mif.mult_opd1_i};
  assign opd2_ext = mif.mult_signed_i ? {{2{mif.mult_opd2_i[OPD_W-1]}}, mif.mult_opd2_i}
                                      : {2'b00, mif.mult_opd2_i};

  // Multiplier is consumed two bits per cycle from the bottom; prev holds b[2i-1].
  booth_r4_sel #(.W(XW)) u_sel (
    .grp   ({mplr[1:0], prev}),
    .mcand (mcand),
    .pp    (pp_mag),
    .neg   (pp_neg)
  );

  assign pp_ext  = {{(AW-XW-1){pp_mag[XW]}}, pp_mag};
  assign addend  = pp_neg ? (~pp_ext + 1'b1) : pp_ext;
  assign acc_nxt = acc + (addend << {cnt, 1'b0});

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (mif.mult_start_i && !mif.flush_i) begin
          accept    = 1'b1;
          state_nxt = MUL_BUSY;
`ifdef MUL_ITER_EARLY_EXIT_EN
          if ((mif.mult_opd1_i == '0) || (mif.mult_opd2_i == '0))
            state_nxt = MUL_DONE;
`endif
        end
      end
      MUL_BUSY: if (cnt == CW'(ITERS-1)) state_nxt = MUL_DONE;
      MUL_DONE: state_nxt = MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
    if (mif.flush_i) state_nxt = MUL_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= MUL_IDLE;
      mcand   <= '0;
      mplr    <= '0;
      prev    <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      end_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      end_q <= (state_nxt == MUL_DONE);
      if (state_nxt == MUL_DONE)
        product <= (state == MUL_BUSY) ? acc_nxt[2*OPD_W-1:0] : '0;
      if (accept) begin
        mcand <= opd1_ext;
        mplr  <= opd2_ext;
        prev  <= 1'b0;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == MUL_BUSY && !mif.flush_i) begin
        acc  <= acc_nxt;
        mplr <= mplr >> 2;
        prev <= mplr[1];
        cnt  <= cnt + 1'b1;
      end
      if (mif.flush_i) cnt <= '0;
    end
  end

  assign mif.product_o   = product;
  assign mif.mult_end_o  = end_q;
  assign mif.mult_busy_o = (state != MUL_IDLE);

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed + random products against an arithmetic model.
module tb_mul_iter;

  localparam int ITERS = 17;
`ifdef MUL_ITER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mul_iter_if #(.OPD_W(32)) mif ();

  mul_iter dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .mif     (mif)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint   sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit s, input string nm);
    logic [63:0] exp;
    int lat, first, pulses;
    exp    = ref_mul(a, b, s);
    lat    = (EE && (a == 0 || b == 0)) ? 1 : ITERS + 1;
    first  = -1;
    pulses = 0;
    @(posedge clk); #1;
    mif.mult_start_i  = 1'b1;
    mif.mult_signed_i = s;
    mif.mult_opd1_i   = a;
    mif.mult_opd2_i   = b;
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mif.mult_start_i  = 1'b0;
        mif.mult_opd1_i   = $urandom;
        mif.mult_opd2_i   = $urandom;
        mif.mult_signed_i = ~s;
        n_cmp++;
        if (mif.mult_busy_o !== 1'b1) begin
          n_fail++; $display("FAIL %s busy: got %b want 1", nm, mif.mult_busy_o);
        end
      end
      if (mif.mult_end_o === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = k;
          n_cmp++;
          if (mif.product_o !== exp) begin
            n_fail++; $display("FAIL %s product: got %h want %h", nm, mif.product_o, exp);
          end
        end
      end
      if (first >= 0 && k == first + 3) begin
        n_cmp++;
        if (mif.product_o !== exp || mif.mult_busy_o !== 1'b0) begin
          n_fail++; $display("FAIL %s hold: got %h busy %b want %h busy 0", nm, mif.product_o, mif.mult_busy_o, exp);
        end
      end
    end
    n_cmp++;
    if (first != lat || pulses != 1) begin
      n_fail++; $display("FAIL %s latency: got cycle %0d pulses %0d want cycle %0d pulses 1", nm, first, pulses, lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mif.mult_start_i = 1'b0; mif.mult_signed_i = 1'b0; mif.flush_i = 1'b0;
    mif.mult_opd1_i = '0; mif.mult_opd2_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (mif.mult_end_o !== 1'b0 || mif.mult_busy_o !== 1'b0 || mif.product_o !== 64'd0) begin
      n_fail++; $display("FAIL reset: got end %b busy %b prod %h want 0 0 0", mif.mult_end_o, mif.mult_busy_o, mif.product_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_mul(32'd3, 32'd5, 1'b0, "u3x5");
    run_mul(32'hFFFF_FFFE, 32'd3, 1'b1, "s_m2x3");
    run_mul(32'hFFFF_FFFE, 32'd3, 1'b0, "u_fffex3");
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max");
    run_mul(32'h8000_0000, 32'h8000_0000, 1'b1, "s_min");
    run_mul(32'd0, 32'h1234, 1'b0, "zero_a");
    run_mul(32'hDEAD_BEEF, 32'd0, 1'b1, "zero_b");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 7 == 3) a = 32'd0;
      run_mul(a, b, bit'($urandom_range(1, 0)), "rand");
    end
  endtask

  task automatic test_flush();
    int pulses;
    @(posedge clk); #1;
    mif.mult_start_i = 1'b1; mif.mult_signed_i = 1'b0;
    mif.mult_opd1_i = 32'h1234; mif.mult_opd2_i = 32'h5678;
    pulses = 0;
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) mif.mult_start_i = 1'b0;
      if (k == 5) mif.flush_i = 1'b1;
      if (k == 6) begin
        mif.flush_i = 1'b0;
        n_cmp++;
        if (mif.mult_busy_o !== 1'b0) begin
          n_fail++; $display("FAIL flush busy: got %b want 0", mif.mult_busy_o);
        end
      end
      if (mif.mult_end_o === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL flush pulses: got %0d want 0", pulses);
    end
    // flush beats a simultaneous start in IDLE
    @(posedge clk); #1;
    mif.mult_start_i = 1'b1; mif.flush_i = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (mif.mult_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_vs_start busy: got %b want 0", mif.mult_busy_o);
    end
    mif.mult_start_i = 1'b0; mif.flush_i = 1'b0;
    run_mul(32'd7, 32'd6, 1'b0, "after_flush");
  endtask

  task automatic test_back_to_back();
    int p1, p2, pulses;
    logic [63:0] v1, v2;
    p1 = -1; p2 = -1; pulses = 0; v1 = '0; v2 = '0;
    @(posedge clk); #1;
    mif.mult_start_i = 1'b1; mif.mult_signed_i = 1'b0;
    mif.mult_opd1_i = 32'd2; mif.mult_opd2_i = 32'd2;
    for (int k = 0; k <= 90; k++) begin
      @(negedge clk);
      if (mif.mult_end_o === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          p1 = k; v1 = mif.product_o;
          mif.mult_opd1_i = 32'd9; mif.mult_opd2_i = 32'd9;
        end else if (pulses == 2) begin
          p2 = k; v2 = mif.product_o;
          mif.mult_start_i = 1'b0;
        end
      end
    end
    mif.mult_start_i = 1'b0;
    n_cmp++;
    if (p1 != ITERS + 1 || v1 !== 64'd4) begin
      n_fail++; $display("FAIL b2b first: got cycle %0d val %h want cycle %0d val 4", p1, v1, ITERS + 1);
    end
    n_cmp++;
    if (p2 != 2*ITERS + 3 || v2 !== 64'd81) begin
      n_fail++; $display("FAIL b2b second: got cycle %0d val %h want cycle %0d val 51", p2, v2, 2*ITERS + 3);
    end
    n_cmp++;
    if (pulses != 2) begin
      n_fail++; $display("FAIL b2b pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    mif.mult_start_i = 1'b1; mif.mult_signed_i = 1'b1;
    mif.mult_opd1_i = 32'h0BAD_F00D; mif.mult_opd2_i = 32'h0000_0777;
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) mif.mult_start_i = 1'b0;
      if (k == 10) rst_n = 1'b0;
      if (k == 11) begin
        rst_n = 1'b1;
        n_cmp++;
        if (mif.mult_end_o !== 1'b0 || mif.mult_busy_o !== 1'b0 || mif.product_o !== 64'd0) begin
          n_fail++; $display("FAIL reset_mid outputs: got end %b busy %b prod %h want 0 0 0", mif.mult_end_o, mif.mult_busy_o, mif.product_o);
        end
      end
      if (mif.mult_end_o === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL reset_mid pulses: got %0d want 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
